// File: rtl/hyp_scale_pipe.sv
// Purpose : scales a signed sample by sinh(0.5) and cosh(0.5) using shift-add networks; optional exp(0.5) output.
// Latency : 3 cycles from input transfer to oValid. One sample per cycle while oReady is high.
// Backpr. : each stage loads when it is empty or its successor loads. oReady low stalls the pipe and holds the outputs.
//           iReady falls once all three stages are full.
//
// Ports   : iClk/iRst (async, active-high), iValid/iReady/iData/iTag in, oValid/oReady/sinhOut/coshOut/oTag out.
// Option  : define HYPCORD_EXP_EN to add expOut = sat(sinh + cosh), summed before saturation.
module hyp_scale_pipe #(
    parameter int DWIDTH    = 16,   // matches hyperCord_pkg::IDWIDTH
    parameter int TAG_WIDTH = 4
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iValid,
    output logic                     iReady,
    input  logic signed [DWIDTH-1:0] iData,
    input  logic [TAG_WIDTH-1:0]     iTag,
    output logic                     oValid,
    input  logic                     oReady,
    output logic signed [DWIDTH-1:0] sinhOut,
    output logic signed [DWIDTH-1:0] coshOut,
`ifdef HYPCORD_EXP_EN
    output logic signed [DWIDTH-1:0] expOut,
`endif
    output logic [TAG_WIDTH-1:0]     oTag
);

    // Two guard bits. They cover the cosh gain (~1.13), the intermediate c (~1.34)
    // and sinh+cosh (~1.65) with no internal wrap.
    localparam int IW = DWIDTH + 2;
    typedef logic signed [IW-1:0] iw_t;

    // Clamp to the signed DWIDTH range. The value is in range when the top 3 bits
    // agree, i.e. the guard bits are copies of the result sign.
    function automatic logic signed [DWIDTH-1:0] sat(input iw_t v);
        logic [2:0] top;
        top = v[IW-1:DWIDTH-1];
        if (top == 3'b000 || top == 3'b111)
            return v[DWIDTH-1:0];
        else if (v[IW-1])
            return {1'b1, {(DWIDTH-1){1'b0}}};
        else
            return {1'b0, {(DWIDTH-1){1'b1}}};
    endfunction

    // Handshake: a stage loads when it is empty or the stage after it loads.
    logic v1, v2, v3;
    logic en1, en2, en3;

    assign en3    = !v3 || oReady;
    assign en2    = !v2 || en3;
    assign en1    = !v1 || en2;
    assign iReady = en1;
    assign oValid = v3;

    // Stage 1: start the sinh term a. Start the first half of the cosh sum.
    iw_t x_ext, a_c, ch1_c;
    assign x_ext = {{2{iData[DWIDTH-1]}}, iData};
    assign a_c   = x_ext + (x_ext >>> 2);
    assign ch1_c = x_ext + (x_ext >>> 3) + (x_ext >>> 9);

    iw_t                  s1_x, s1_a, s1_ch;
    logic [TAG_WIDTH-1:0] s1_tag;

    // Stage 2: finish sinh up to d. Finish the cosh sum.
    iw_t b_c, c_c, d_c, ch2_c;
    assign b_c   = (s1_a >>> 4) + (s1_x >>> 6);
    assign c_c   = s1_a + b_c;
    assign d_c   = (c_c >>> 5) + s1_x;
    assign ch2_c = s1_ch + (s1_x >>> 11) + (s1_x >>> 13) + (s1_x >>> 14);

    iw_t                  s2_d, s2_ch;
    logic [TAG_WIDTH-1:0] s2_tag;

    // Stage 3: final halving of sinh, then saturation into the output registers.
    iw_t sh_c;
    assign sh_c = s2_d >>> 1;
`ifdef HYPCORD_EXP_EN
    iw_t ex_c;
    assign ex_c = sh_c + s2_ch;
`endif

    // Data registers need no reset. The valid bits say when their contents are meaningful.
    always_ff @(posedge iClk) begin
        if (en1 && iValid) begin
            s1_x   <= x_ext;
            s1_a   <= a_c;
            s1_ch  <= ch1_c;
            s1_tag <= iTag;
        end
        if (en2 && v1) begin
            s2_d   <= d_c;
            s2_ch  <= ch2_c;
            s2_tag <= s1_tag;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            sinhOut <= '0;
            coshOut <= '0;
            oTag    <= '0;
`ifdef HYPCORD_EXP_EN
            expOut  <= '0;
`endif
        end else begin
            if (en1) v1 <= iValid;
            if (en2) v2 <= v1;
            if (en3) begin
                v3 <= v2;
                // Outputs change only when a new result moves in, so a stall holds them stable.
                if (v2) begin
                    sinhOut <= sat(sh_c);
                    coshOut <= sat(s2_ch);
                    oTag    <= s2_tag;
`ifdef HYPCORD_EXP_EN
                    expOut  <= sat(ex_c);
`endif
                end
            end
        end
    end

endmodule
